core_ibex_ifetch_pmp_evt_buf: RTL and testbench
===============================================

// Module: core_ibex_ifetch_pmp_evt_buf
// PURPOSE
//  Multi-channel successor to the single-channel ifetch PMP monitor interface.
//  Samples NumChan instruction-fetch ports each clk and queues qualifying fetch events in a FIFO.
//  Queued events are drained by the cosim agent through a valid/ready read port.
//  Keeps sticky overflow, saturating drop and PMP-error counters.
//  Sits in the DV harness beside core_ibex_ifetch_pmp_if; purely observational, never back-pressures the core.
// PARAMETERS
//  NumChan   2   number of fetch channels sampled (1..8)
//  AddrW     32  fetch address width
//  Depth     8   FIFO entries; power of two, >=2
//  CntW      16  width of drop_cnt_o / err_cnt_o
//  TsW       32  timestamp width (used only with IBEX_IFETCH_PMP_TS_EN)
// PORTS
//  clk              in   1                clock
//  reset            in   1                async reset, active-high
//  fetch_valid_i    in   NumChan          per-channel fetch valid
//  fetch_addr_i     in   NumChan*AddrW    per-channel address; chan c at [c*AddrW +: AddrW]
//  fetch_pmp_err_i  in   NumChan          per-channel PMP fetch error
//  err_only_i       in   1                1: queue only events with pmp_err=1
//  clear_i          in   1                sync flush of FIFO, counters, overflow
//  rd_valid_o       out  1                FIFO head valid
//  rd_ready_i       in   1                consumer accepts head
//  rd_chan_o        out  $clog2(NumChan)  head channel index (1 bit min)
//  rd_addr_o        out  AddrW            head fetch address
//  rd_pmp_err_o     out  1                head PMP error flag
//  rd_ts_o          out  TsW              head timestamp (macro only)
//  level_o          out  $clog2(Depth+1)  occupied entries
//  overflow_o       out  1                sticky: at least one event dropped
//  drop_cnt_o       out  CntW             dropped events, saturating
//  err_cnt_o        out  CntW             qualifying pmp_err events seen, saturating
// BEHAVIOUR
//  - Reset (async, reset=1): FIFO empty, rd_valid_o=0, rd_* data=0, level_o=0, overflow_o=0, counters=0.
//  - Qualifying event on chan c: fetch_valid_i[c] & (!err_only_i | fetch_pmp_err_i[c]).
//  - Pop: rd_valid_o & rd_ready_i; head advances at the next edge.
//  - Space in cycle N: Depth - level + pop. Same-cycle pop frees one slot for that cycle's pushes.
//  - Push: all qualifying events of one cycle are written in the same cycle, ascending channel order.
//    Excess beyond space is dropped, highest channel index first.
//  - Latency: event sampled at edge N appears on rd_* after edge N (rd_valid_o=1 in cycle N+1) when FIFO was empty.
//    No bypass exists within cycle N.
//  - rd_* data is stable while rd_valid_o=1 and !rd_ready_i. rd_* data is don't-care when rd_valid_o=0.
//  - Drops set overflow_o (sticky) and add the number dropped to drop_cnt_o.
//  - err_cnt_o adds count(qualifying & pmp_err), including dropped events.
//  - Counters saturate at 2**CntW-1 and never wrap.
//  - Pointers wrap modulo Depth. level_o next = level + pushes - pop, range 0..Depth.
//  - Full (level=Depth) with pop: up to 1 push accepted. Full without pop: all events dropped.
//  - Empty: rd_ready_i is ignored; no underflow.
//  - clear_i=1 takes priority over push/pop/count in that cycle.
//    Result: level 0, counters 0, overflow 0; events in that cycle are discarded and not counted.
//  - Reset asserted mid-operation: all state returns to reset values immediately; in-flight pop is lost.
//  - err_only_i may change any cycle. It affects only events sampled in that cycle.
// CONFIGURATION
//  IBEX_IFETCH_PMP_TS_EN defined:
//   - a free-running TsW counter, reset 0, +1 per clk, wraps, is not cleared by clear_i.
//   - Each entry stores the counter value of its sample cycle. rd_ts_o presents the head timestamp.
//  Not defined: no counter or timestamp storage; rd_ts_o tied to 0.
// TESTING
//  1. Reset, chan0 valid addr=0x8000_0000 err=0, err_only_i=0, rd_ready_i=0
//     -> next cycle rd_valid_o=1, rd_chan_o=0, rd_addr_o=0x8000_0000, level_o=1.
//  2. Same cycle chan0 0x100/err=1 and chan1 0x200/err=0
//     -> pops return chan0 then chan1; err_cnt_o=1.
//  3. Depth=8: fill 8 entries; next cycle both channels valid, rd_ready_i=0
//     -> drop_cnt_o=2, overflow_o=1, level_o=8.
//  4. FIFO full, rd_ready_i=1 and both channels valid
//     -> chan0 accepted, chan1 dropped, level_o stays 8, drop_cnt_o+1.
//  5. err_only_i=1, chan0 err=0 and chan1 err=1
//     -> only chan1 queued. Then clear_i=1 with chan0 valid -> level_o=0, counters 0, nothing queued.
//  6. With IBEX_IFETCH_PMP_TS_EN: events 5 cycles after reset and 9 cycles after reset -> rd_ts_o=5 then 9.
//     Assert reset mid-drain -> rd_valid_o=0 immediately.

Source files
------------

// File: rtl/core_ibex_ifetch_pmp_evt_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_ibex_ifetch_pmp_evt_buf                                             |
// | Multi-channel ifetch PMP event FIFO with overflow, drop and error counts.|
// | Optional: define IBEX_IFETCH_PMP_TS_EN to timestamp each queued event.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module core_ibex_ifetch_pmp_evt_buf #(
    parameter int NumChan = 2,
    parameter int AddrW   = 32,
    parameter int Depth   = 8,
    parameter int CntW    = 16,
    parameter int TsW     = 32
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NumChan-1:0]                             fetch_valid_i,
    input  logic [NumChan*AddrW-1:0]                       fetch_addr_i,
    input  logic [NumChan-1:0]                             fetch_pmp_err_i,
    input  logic                                           err_only_i,
    input  logic                                           clear_i,
    output logic                                           rd_valid_o,
    input  logic                                           rd_ready_i,
    output logic [((NumChan > 1) ? $clog2(NumChan) : 1)-1:0] rd_chan_o,
    output logic [AddrW-1:0]                               rd_addr_o,
    output logic                                           rd_pmp_err_o,
    output logic [TsW-1:0]                                 rd_ts_o,
    output logic [$clog2(Depth+1)-1:0]                     level_o,
    output logic                                           overflow_o,
    output logic [CntW-1:0]                                drop_cnt_o,
    output logic [CntW-1:0]                                err_cnt_o
);

    localparam int CHW  = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int PTRW = $clog2(Depth);
    localparam int LVLW = $clog2(Depth+1);
    localparam int NCW  = $clog2(NumChan+1);
    localparam logic [LVLW:0] DEPTH_L = (LVLW+1)'(Depth);

    logic [CHW-1:0]   chan_q [Depth];
    logic [AddrW-1:0] addr_q [Depth];
    logic             perr_q [Depth];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0] level_q, level_d;
    logic            ovf_q, ovf_d;
    logic [CntW-1:0] drop_q, drop_d, errc_q, errc_d;

    logic               pop;
    logic [LVLW:0]      space;
    logic [LVLW-1:0]    n_push;
    logic [NCW-1:0]     n_drop, n_err;
    logic [NumChan-1:0] accept;
    logic [PTRW-1:0]    widx [NumChan];

    function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a, input logic [NCW-1:0] b);
        logic [CntW:0] s;
        s = {1'b0, a} + (CntW+1)'(b);
        return s[CntW] ? {CntW{1'b1}} : s[CntW-1:0];
    endfunction

    // Channels claim free slots in ascending order, so overflow drops the highest indices.
    always_comb begin
        pop    = rd_valid_o & rd_ready_i;
        space  = DEPTH_L - {1'b0, level_q} + {{LVLW{1'b0}}, pop};
        n_push = '0;
        n_drop = '0;
        n_err  = '0;
        accept = '0;
        for (int c = 0; c < NumChan; c++) begin
            widx[c] = wr_ptr_q + n_push[PTRW-1:0];
            if (fetch_valid_i[c] & (~err_only_i | fetch_pmp_err_i[c])) begin
                if (fetch_pmp_err_i[c]) n_err = n_err + NCW'(1);
                if ({1'b0, n_push} < space) begin
                    accept[c] = 1'b1;
                    n_push    = n_push + LVLW'(1);
                end else begin
                    n_drop = n_drop + NCW'(1);
                end
            end
        end

        wr_ptr_d = wr_ptr_q + n_push[PTRW-1:0];
        rd_ptr_d = pop ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
        level_d  = level_q + n_push - LVLW'(pop);
        ovf_d    = ovf_q | (n_drop != '0);
        drop_d   = sat_add(drop_q, n_drop);
        errc_d   = sat_add(errc_q, n_err);

        if (clear_i) begin
            accept   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
            errc_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            errc_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                chan_q[i] <= '0;
                addr_q[i] <= '0;
                perr_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            errc_q   <= errc_d;
            for (int c = 0; c < NumChan; c++) begin
                if (accept[c]) begin
                    chan_q[widx[c]] <= CHW'(c);
                    addr_q[widx[c]] <= fetch_addr_i[c*AddrW +: AddrW];
                    perr_q[widx[c]] <= fetch_pmp_err_i[c];
                end
            end
        end
    end

`ifdef IBEX_IFETCH_PMP_TS_EN
    // Free-running; deliberately not affected by clear_i.
    logic [TsW-1:0] ts_cnt_q;
    logic [TsW-1:0] ts_mem_q [Depth];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_q <= '0;
            for (int i = 0; i < Depth; i++) ts_mem_q[i] <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TsW'(1);
            for (int c = 0; c < NumChan; c++) begin
                if (accept[c]) ts_mem_q[widx[c]] <= ts_cnt_q;
            end
        end
    end

    assign rd_ts_o = ts_mem_q[rd_ptr_q];
`else
    assign rd_ts_o = '0;
`endif

    assign rd_valid_o   = (level_q != '0);
    assign rd_chan_o    = chan_q[rd_ptr_q];
    assign rd_addr_o    = addr_q[rd_ptr_q];
    assign rd_pmp_err_o = perr_q[rd_ptr_q];
    assign level_o      = level_q;
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_q;
    assign err_cnt_o    = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_core_ibex_ifetch_pmp_evt_buf.sv
`default_nettype none
// Testbench for core_ibex_ifetch_pmp_evt_buf: directed scenarios plus random traffic
// compared against a queue-based event model.
module tb_core_ibex_ifetch_pmp_evt_buf;

    localparam int NCH = 2, AW = 32, DEPTH = 8, CW = 16, TW = 32;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  fetch_valid_i;
    logic [NCH*AW-1:0] fetch_addr_i;
    logic [NCH-1:0]  fetch_pmp_err_i;
    logic            err_only_i, clear_i, rd_ready_i;
    logic            rd_valid_o, rd_pmp_err_o, overflow_o;
    logic [0:0]      rd_chan_o;
    logic [AW-1:0]   rd_addr_o;
    logic [TW-1:0]   rd_ts_o;
    logic [3:0]      level_o;
    logic [CW-1:0]   drop_cnt_o, err_cnt_o;

    core_ibex_ifetch_pmp_evt_buf #(
        .NumChan(NCH), .AddrW(AW), .Depth(DEPTH), .CntW(CW), .TsW(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_valid_i(fetch_valid_i), .fetch_addr_i(fetch_addr_i),
        .fetch_pmp_err_i(fetch_pmp_err_i), .err_only_i(err_only_i), .clear_i(clear_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_chan_o(rd_chan_o),
        .rd_addr_o(rd_addr_o), .rd_pmp_err_o(rd_pmp_err_o), .rd_ts_o(rd_ts_o),
        .level_o(level_o), .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          chan;
        logic [31:0] addr;
        bit          err;
        int unsigned ts;
    } ev_t;

    ev_t         mq[$];
    int          m_drop, m_err;
    bit          m_ovf;
    int unsigned m_ts;
    int          checks, errors;

    task automatic set_in(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [1:0] e, input logic eo, input logic rdy, input logic clr);
        fetch_valid_i   = v;
        fetch_addr_i    = {a1, a0};
        fetch_pmp_err_i = e;
        err_only_i      = eo;
        rd_ready_i      = rdy;
        clear_i         = clr;
    endtask

    // Advance one clock, updating the event model from the inputs seen at that edge.
    task automatic tick();
        int   space, taken;
        bit   pop;
        ev_t  ev;
        if (clear_i) begin
            mq.delete();
            m_drop = 0;
            m_err  = 0;
            m_ovf  = 0;
        end else begin
            pop   = (mq.size() > 0) && rd_ready_i;
            space = DEPTH - mq.size() + (pop ? 1 : 0);
            if (pop) void'(mq.pop_front());
            taken = 0;
            for (int c = 0; c < NCH; c++) begin
                if (fetch_valid_i[c] && (!err_only_i || fetch_pmp_err_i[c])) begin
                    if (fetch_pmp_err_i[c]) m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
                    if (taken < space) begin
                        ev.chan = c;
                        ev.addr = fetch_addr_i[c*AW +: AW];
                        ev.err  = fetch_pmp_err_i[c];
                        ev.ts   = m_ts;
                        mq.push_back(ev);
                        taken++;
                    end else begin
                        m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
                        m_ovf  = 1;
                    end
                end
            end
        end
        m_ts++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_drop = 0;
        m_err  = 0;
        m_ovf  = 0;
        m_ts   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rd_valid_o); end
        if (level_o !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_o); end
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow_o); end
        if (drop_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got drop %0d err %0d expected 0 0", drop_cnt_o, err_cnt_o);
        end
        if (rd_addr_o !== 32'd0 || rd_chan_o !== 1'b0 || rd_pmp_err_o !== 1'b0 || rd_ts_o !== 32'd0) begin
            errors++; $display("FAIL reset_data: got addr %0h chan %0d err %0b ts %0d expected zeros",
                               rd_addr_o, rd_chan_o, rd_pmp_err_o, rd_ts_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_in(2'b01, 32'h8000_0000, 0, 2'b00, 0, 0, 0);
        tick();
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
        checks += 2;
        if (rd_valid_o !== 1'b1 || level_o !== 4'd1) begin
            errors++; $display("FAIL single_valid: got valid %0b level %0d expected 1 1", rd_valid_o, level_o);
        end
        if (rd_chan_o !== 1'b0 || rd_addr_o !== 32'h8000_0000 || rd_pmp_err_o !== 1'b0) begin
            errors++; $display("FAIL single_head: got chan %0d addr %0h err %0b expected 0 80000000 0",
                               rd_chan_o, rd_addr_o, rd_pmp_err_o);
        end
        set_in(2'b00, 0, 0, 2'b00, 0, 1, 0);
        tick();
        tick();
        checks++;
        if (rd_valid_o !== 1'b0 || level_o !== 4'd0) begin
            errors++; $display("FAIL single_drain: got valid %0b level %0d expected 0 0", rd_valid_o, level_o);
        end
    endtask

    task automatic test_order();
        do_reset();
        set_in(2'b11, 32'h100, 32'h200, 2'b01, 0, 0, 0);
        tick();
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
        checks += 2;
        if (err_cnt_o !== 16'd1 || level_o !== 4'd2) begin
            errors++; $display("FAIL order_cnt: got err %0d level %0d expected 1 2", err_cnt_o, level_o);
        end
        if (rd_chan_o !== 1'b0 || rd_addr_o !== 32'h100 || rd_pmp_err_o !== 1'b1) begin
            errors++; $display("FAIL order_first: got chan %0d addr %0h err %0b expected 0 100 1",
                               rd_chan_o, rd_addr_o, rd_pmp_err_o);
        end
        rd_ready_i = 1'b1;
        tick();
        checks++;
        if (rd_chan_o !== 1'b1 || rd_addr_o !== 32'h200 || rd_pmp_err_o !== 1'b0 || level_o !== 4'd1) begin
            errors++; $display("FAIL order_second: got chan %0d addr %0h err %0b level %0d expected 1 200 0 1",
                               rd_chan_o, rd_addr_o, rd_pmp_err_o, level_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(2'b11, 32'h1000 + 32'(i*8), 32'h1004 + 32'(i*8), 2'b00, 0, 0, 0);
            tick();
        end
        checks++;
        if (level_o !== 4'd8 || overflow_o !== 1'b0) begin
            errors++; $display("FAIL fill: got level %0d ovf %0b expected 8 0", level_o, overflow_o);
        end
        set_in(2'b11, 32'h2000, 32'h2004, 2'b10, 0, 0, 0);
        tick();
        checks += 2;
        if (drop_cnt_o !== 16'd2 || overflow_o !== 1'b1 || level_o !== 4'd8) begin
            errors++; $display("FAIL full_drop: got drop %0d ovf %0b level %0d expected 2 1 8",
                               drop_cnt_o, overflow_o, level_o);
        end
        if (err_cnt_o !== 16'd1) begin
            errors++; $display("FAIL full_errcnt: got %0d expected 1", err_cnt_o);
        end
        set_in(2'b11, 32'h3000, 32'h3004, 2'b00, 0, 1, 0);
        tick();
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
        checks += 2;
        if (drop_cnt_o !== 16'd3 || level_o !== 4'd8) begin
            errors++; $display("FAIL full_pop: got drop %0d level %0d expected 3 8", drop_cnt_o, level_o);
        end
        if (rd_chan_o !== 1'b1 || rd_addr_o !== 32'h1004) begin
            errors++; $display("FAIL full_pop_head: got chan %0d addr %0h expected 1 1004", rd_chan_o, rd_addr_o);
        end
        rd_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (rd_chan_o !== 1'b0 || rd_addr_o !== 32'h3000 || level_o !== 4'd1) begin
            errors++; $display("FAIL full_tail: got chan %0d addr %0h level %0d expected 0 3000 1",
                               rd_chan_o, rd_addr_o, level_o);
        end
    endtask

    task automatic test_err_only_clear();
        do_reset();
        set_in(2'b11, 32'hA0, 32'hB0, 2'b10, 1, 0, 0);
        tick();
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
        checks++;
        if (level_o !== 4'd1 || rd_chan_o !== 1'b1 || rd_addr_o !== 32'hB0 || err_cnt_o !== 16'd1) begin
            errors++; $display("FAIL err_only: got level %0d chan %0d addr %0h err %0d expected 1 1 b0 1",
                               level_o, rd_chan_o, rd_addr_o, err_cnt_o);
        end
        set_in(2'b01, 32'hC0, 0, 2'b01, 0, 1, 1);
        tick();
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
        checks++;
        if (level_o !== 4'd0 || rd_valid_o !== 1'b0 || err_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0 ||
            overflow_o !== 1'b0) begin
            errors++; $display("FAIL clear: got level %0d valid %0b err %0d drop %0d ovf %0b expected all 0",
                               level_o, rd_valid_o, err_cnt_o, drop_cnt_o, overflow_o);
        end
    endtask

    task automatic test_timestamp();
        do_reset();
        while (m_ts < 5) tick();
        set_in(2'b01, 32'h55, 0, 2'b00, 0, 0, 0);
        tick();
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
        while (m_ts < 9) tick();
        set_in(2'b10, 0, 32'h99, 2'b00, 0, 0, 0);
        tick();
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
`ifdef IBEX_IFETCH_PMP_TS_EN
        checks++;
        if (rd_ts_o !== 32'd5) begin errors++; $display("FAIL ts_first: got %0d expected 5", rd_ts_o); end
        rd_ready_i = 1'b1;
        tick();
        checks++;
        if (rd_ts_o !== 32'd9) begin errors++; $display("FAIL ts_second: got %0d expected 9", rd_ts_o); end
`else
        checks++;
        if (rd_ts_o !== 32'd0) begin errors++; $display("FAIL ts_tied: got %0d expected 0", rd_ts_o); end
        rd_ready_i = 1'b1;
        tick();
`endif
        // Reset lands between edges while a pop is being requested.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_valid_o !== 1'b0 || level_o !== 4'd0) begin
            errors++; $display("FAIL mid_reset: got valid %0b level %0d expected 0 0", rd_valid_o, level_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_drop = 0;
        m_err  = 0;
        m_ovf  = 0;
        m_ts   = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_ts;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_in(2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
            tick();
            checks += 3;
            if (rd_valid_o !== (mq.size() > 0) || level_o !== 4'(mq.size())) begin
                errors++; $display("FAIL rnd_level[%0d]: got valid %0b level %0d expected %0b %0d",
                                   n, rd_valid_o, level_o, (mq.size() > 0), mq.size());
            end
            if (overflow_o !== m_ovf || drop_cnt_o !== 16'(m_drop) || err_cnt_o !== 16'(m_err)) begin
                errors++; $display("FAIL rnd_cnt[%0d]: got ovf %0b drop %0d err %0d expected %0b %0d %0d",
                                   n, overflow_o, drop_cnt_o, err_cnt_o, m_ovf, m_drop, m_err);
            end
            if (mq.size() > 0) begin
`ifdef IBEX_IFETCH_PMP_TS_EN
                exp_ts = mq[0].ts;
`else
                exp_ts = 32'd0;
`endif
                if (rd_chan_o !== 1'(mq[0].chan) || rd_addr_o !== mq[0].addr ||
                    rd_pmp_err_o !== mq[0].err || rd_ts_o !== exp_ts) begin
                    errors++; $display("FAIL rnd_head[%0d]: got chan %0d addr %0h err %0b ts %0d expected %0d %0h %0b %0d",
                                       n, rd_chan_o, rd_addr_o, rd_pmp_err_o, rd_ts_o,
                                       mq[0].chan, mq[0].addr, mq[0].err, exp_ts);
                end
            end else if (rd_valid_o !== 1'b0) begin
                errors++; $display("FAIL rnd_empty[%0d]: got valid %0b expected 0", n, rd_valid_o);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_in(2'b00, 0, 0, 2'b00, 0, 0, 0);
        #2;
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_err_only_clear();
        test_timestamp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
